i3c_ahb_csr_mgr: RTL and testbench

I3C_AHB_CSR_MGR -- requirements
Module: i3c_ahb_csr_mgr

---
 rtl/i3c_pkg.sv | 37 +++
 rtl/i3c_ahb_csr_mgr_if.sv | 69 ++++++
 rtl/i3c_ahb_csr_mgr.sv | 221 ++++++++++++++++++++++
 tb/tb_i3c_ahb_csr_mgr.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// -----------------------------------------------------------------------------
// i3c_pkg
// Shared types and AHB-Lite encodings for the I3C AHB CSR manager.
//   - mgr_state_e     : manager FSM state encoding
//   - HTRANS_* / HBURST_* / HPROT_* : AHB-Lite control encodings
//   - hsize_for_width : HSIZE value for a full-width beat of a given bus width
// Default bus widths come from `AHB_ADDR_WIDTH / `AHB_DATA_WIDTH. Both fall back
// to 32 when the build does not define them.
// -----------------------------------------------------------------------------
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package i3c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } mgr_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // HSIZE encodes log2 of the beat size in bytes; always a full-width beat here.
    function automatic logic [2:0] hsize_for_width(input int data_width);
        hsize_for_width = 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/i3c_ahb_csr_mgr_if.sv
// -----------------------------------------------------------------------------
// i3c_ahb_csr_mgr_if
// Bundles the request/response handshake and the AHB-Lite manager signals of
// i3c_ahb_csr_mgr.
//   master : view of the manager (the design)
//   slave  : view of the requester plus AHB subordinate (environment)
// Parameters: AhbAddrWidth, AhbDataWidth (32 or 64).
// -----------------------------------------------------------------------------
interface i3c_ahb_csr_mgr_if #(
    parameter int AhbAddrWidth = `AHB_ADDR_WIDTH,
    parameter int AhbDataWidth = `AHB_DATA_WIDTH
);
    localparam int StrbWidth = AhbDataWidth / 8;

    // request channel
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_write_i;
    logic [AhbAddrWidth-1:0] req_addr_i;
    logic [AhbDataWidth-1:0] req_wdata_i;
    logic [StrbWidth-1:0]    req_wstrb_i;

    // response channel
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [AhbDataWidth-1:0] rsp_rdata_o;
    logic                    rsp_err_o;

    // AHB-Lite manager side
    logic [AhbAddrWidth-1:0] haddr_o;
    logic                    hwrite_o;
    logic [2:0]              hsize_o;
    logic [1:0]              htrans_o;
    logic [2:0]              hburst_o;
    logic [3:0]              hprot_o;
    logic                    hsel_o;
    logic                    hready_o;
    logic [AhbDataWidth-1:0] hwdata_o;
    logic [StrbWidth-1:0]    hwstrb_o;
    logic [AhbDataWidth-1:0] hrdata_i;
    logic                    hreadyout_i;
    logic                    hresp_i;

    // sticky status
    logic                    timeout_o;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output haddr_o, hwrite_o, hsize_o, htrans_o, hburst_o, hprot_o,
        output hsel_o, hready_o, hwdata_o, hwstrb_o,
        input  hrdata_i, hreadyout_i, hresp_i,
        output timeout_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  haddr_o, hwrite_o, hsize_o, htrans_o, hburst_o, hprot_o,
        input  hsel_o, hready_o, hwdata_o, hwstrb_o,
        output hrdata_i, hreadyout_i, hresp_i,
        input  timeout_o
    );

endinterface

// File: rtl/i3c_ahb_csr_mgr.sv
// -----------------------------------------------------------------------------
// i3c_ahb_csr_mgr
// Single-outstanding AHB-Lite manager for CSR accesses. A request accepted in
// IDLE issues one SINGLE NONSEQ transfer (ADDR, then DATA until HREADY) and the
// captured read data / HRESP is returned on the response channel (RESP).
// Ports:
//   clk_i  : clock, all logic on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : i3c_ahb_csr_mgr_if.master (request, response, AHB-Lite, timeout_o)
// Parameters: AhbAddrWidth, AhbDataWidth (32/64), TimeoutCycles.
// Build option: define I3C_AHB_MGR_TIMEOUT_EN to bound the data-phase wait to
// TimeoutCycles cycles; the transfer is then answered with an error, timeout_o
// is set (sticky) and the FSM sits in DRAIN until the subordinate finally
// raises HREADYOUT. Without it, DATA waits indefinitely and timeout_o is 0.
// -----------------------------------------------------------------------------
module i3c_ahb_csr_mgr
    import i3c_pkg::*;
#(
    parameter int AhbAddrWidth  = `AHB_ADDR_WIDTH,
    parameter int AhbDataWidth  = `AHB_DATA_WIDTH,
    parameter int TimeoutCycles = 1024
) (
    input logic               clk_i,
    input logic               rst_i,
    i3c_ahb_csr_mgr_if.master bus
);

    localparam int StrbWidth = AhbDataWidth / 8;
    localparam int LsbBits   = $clog2(StrbWidth);
    localparam logic [AhbAddrWidth-1:0] AddrLsbMask = AhbAddrWidth'((1 << LsbBits) - 1);
    localparam logic [2:0] HsizeValue = hsize_for_width(AhbDataWidth);

    mgr_state_e              state_r;
    mgr_state_e              state_next_s;
    logic                    req_ready_r;
    logic                    req_fire_s;
    logic                    data_done_s;
    logic                    timeout_hit_s;
    logic                    drain_pending_s;
    logic                    timeout_flag_s;

    logic [1:0]              htrans_r;
    logic                    hsel_r;
    logic [AhbAddrWidth-1:0] haddr_r;
    logic                    hwrite_r;
    logic [AhbDataWidth-1:0] wdata_r;
    logic [StrbWidth-1:0]    wstrb_r;
    logic [AhbDataWidth-1:0] hwdata_r;
    logic [StrbWidth-1:0]    hwstrb_r;

    logic                    rsp_valid_r;
    logic [AhbDataWidth-1:0] rsp_rdata_r;
    logic                    rsp_err_r;

    // req_ready_r is high exactly when the FSM sits in IDLE
    assign req_fire_s  = bus.req_valid_i & req_ready_r;
    assign data_done_s = (state_r == ST_DATA) & bus.hreadyout_i;

`ifdef I3C_AHB_MGR_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles) + 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] wait_cnt_r;
    logic                timed_out_r;
    logic                timeout_r;

    // The wait cycle that would be number TimeoutCycles aborts the data phase.
    assign timeout_hit_s   = (state_r == ST_DATA) & ~bus.hreadyout_i & (wait_cnt_r == CntLast);
    assign drain_pending_s = timed_out_r;
    assign timeout_flag_s  = timeout_r;

    // Wait-state counter, drain marker and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_r  <= {CntWidth{1'b0}};
            timed_out_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            if ((state_r == ST_DATA) && !bus.hreadyout_i && !timeout_hit_s) begin
                wait_cnt_r <= wait_cnt_r + CntWidth'(1);
            end else begin
                wait_cnt_r <= {CntWidth{1'b0}};
            end
            if (timeout_hit_s) begin
                timed_out_r <= 1'b1;
                timeout_r   <= 1'b1;
            end else if ((state_r == ST_DRAIN) && bus.hreadyout_i) begin
                // abandoned transfer finally retired by the subordinate
                timed_out_r <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit_s   = 1'b0;
    assign drain_pending_s = 1'b0;
    assign timeout_flag_s  = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_fire_s) begin
                    state_next_s = ST_ADDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_next_s = ST_DATA;
            end
            ST_DATA: begin
                if (bus.hreadyout_i || timeout_hit_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    // after a timeout the subordinate still owns the data phase
                    if (drain_pending_s) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (bus.hreadyout_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and state-decoded registered controls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            htrans_r    <= HTRANS_IDLE;
            hsel_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
            htrans_r    <= (state_next_s == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            hsel_r      <= (state_next_s == ST_ADDR);
            rsp_valid_r <= (state_next_s == ST_RESP);
        end
    end

    // Request capture; haddr/hwrite keep their value between transfers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            haddr_r  <= {AhbAddrWidth{1'b0}};
            hwrite_r <= 1'b0;
            wdata_r  <= {AhbDataWidth{1'b0}};
            wstrb_r  <= {StrbWidth{1'b0}};
        end else if (req_fire_s) begin
            haddr_r  <= bus.req_addr_i & ~AddrLsbMask;
            hwrite_r <= bus.req_write_i;
            wdata_r  <= bus.req_wdata_i;
            wstrb_r  <= bus.req_wstrb_i;
        end
    end

    // Write data phase: present data only while in DATA for a write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hwdata_r <= {AhbDataWidth{1'b0}};
            hwstrb_r <= {StrbWidth{1'b0}};
        end else if ((state_next_s == ST_DATA) && hwrite_r) begin
            hwdata_r <= wdata_r;
            hwstrb_r <= wstrb_r;
        end else begin
            hwdata_r <= {AhbDataWidth{1'b0}};
            hwstrb_r <= {StrbWidth{1'b0}};
        end
    end

    // Response capture at the end of the data phase (or on timeout)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_rdata_r <= {AhbDataWidth{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (data_done_s) begin
            rsp_rdata_r <= hwrite_r ? {AhbDataWidth{1'b0}} : bus.hrdata_i;
            rsp_err_r   <= bus.hresp_i;
        end else if (timeout_hit_s) begin
            rsp_rdata_r <= {AhbDataWidth{1'b0}};
            rsp_err_r   <= 1'b1;
        end
    end

    assign bus.req_ready_o = req_ready_r;
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_rdata_o = rsp_rdata_r;
    assign bus.rsp_err_o   = rsp_err_r;
    assign bus.haddr_o     = haddr_r;
    assign bus.hwrite_o    = hwrite_r;
    assign bus.hsize_o     = HsizeValue;
    assign bus.htrans_o    = htrans_r;
    assign bus.hburst_o    = HBURST_SINGLE;
    assign bus.hprot_o     = HPROT_DEFAULT;
    assign bus.hsel_o      = hsel_r;
    assign bus.hready_o    = bus.hreadyout_i;
    assign bus.hwdata_o    = hwdata_r;
    assign bus.hwstrb_o    = hwstrb_r;
    assign bus.timeout_o   = timeout_flag_s;

endmodule

// File: tb/tb_i3c_ahb_csr_mgr.sv
// -----------------------------------------------------------------------------
// tb_i3c_ahb_csr_mgr
// Scoreboard bench for i3c_ahb_csr_mgr. A stimulus process issues directed and
// random requests and, on each handshake, queues a plan for the AHB subordinate
// model and an expected response. The subordinate model checks the address and
// data phases; a response monitor pops and checks every response.
// -----------------------------------------------------------------------------
module tb_i3c_ahb_csr_mgr;

    localparam int AW     = `AHB_ADDR_WIDTH;
    localparam int DW     = `AHB_DATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 8;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] rdata;
        logic          err;
        int            waits;
        int            hold;
        bit            timeout;
        int            hs_cyc;
        int            rsp_cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst_i;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_active = 1'b0;
    bit   sub_busy = 1'b0;
    bit   to_expected = 1'b0;
    txn_t plan_q[$];
    txn_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    i3c_ahb_csr_mgr_if #(.AhbAddrWidth(AW), .AhbDataWidth(DW)) bus ();

    i3c_ahb_csr_mgr #(
        .AhbAddrWidth (AW),
        .AhbDataWidth (DW),
        .TimeoutCycles(TO_CYC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [SW-1:0] ws, input logic [DW-1:0] rd, input logic e,
                                input int w, input int h);
        txn_t t;
        t.write = wr; t.addr = a; t.wdata = wd; t.wstrb = ws; t.rdata = rd; t.err = e;
        t.waits = w; t.hold = h; t.timeout = 1'b0; t.hs_cyc = 0; t.rsp_cyc = 0;
        return t;
    endfunction

    // Issue one request; expectations are queued in the handshake cycle.
    task automatic issue(input txn_t t_in, output int hs);
        txn_t t = t_in;
        int   guard = 0;
        bit   done = 1'b0;
        hs = 0;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = t.write;
        bus.req_addr_i  = t.addr;
        bus.req_wdata_i = t.wdata;
        bus.req_wstrb_i = t.wstrb;
        while (!done) begin
            if (bus.req_ready_o === 1'b1) begin
                hs = cyc;
                t.hs_cyc  = cyc;
                t.rsp_cyc = t.timeout ? cyc + 2 + TO_CYC : cyc + 3 + t.waits;
                plan_q.push_back(t);
                exp_q.push_back(t);
                done = 1'b1;
            end else if (guard > 300) begin
                chk("req_accept_bound", bus.req_ready_o, 1);
                done = 1'b1;
            end else begin
                guard++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_wdata_i = DW'($urandom);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || mon_active || sub_busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending_rsp", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_htrans"}, bus.htrans_o, 0);
        chk({tag, "_hsel"}, bus.hsel_o, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err_o, 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata_o, 0);
        chk({tag, "_hwdata"}, bus.hwdata_o, 0);
        chk({tag, "_hwstrb"}, bus.hwstrb_o, 0);
        chk({tag, "_haddr"}, bus.haddr_o, 0);
        chk({tag, "_hwrite"}, bus.hwrite_o, 0);
        chk({tag, "_timeout"}, bus.timeout_o, 0);
        chk({tag, "_req_ready"}, bus.req_ready_o, 1);
    endtask

    // AHB subordinate model: follows the plan of the transfer it is serving
    initial begin : sub_model
        txn_t cur;
        int   k = 0;
        bus.hreadyout_i = 1'b1;
        bus.hresp_i     = 1'b0;
        bus.hrdata_i    = '0;
        forever begin
            @(negedge clk);
            if (rst_i === 1'b1) begin
                sub_busy = 1'b0;
                bus.hreadyout_i = 1'b1;
                bus.hresp_i     = 1'b0;
            end else if (!sub_busy) begin
                bus.hreadyout_i = 1'b1;
                bus.hresp_i     = 1'b0;
                bus.hrdata_i    = DW'($urandom);
                if (bus.htrans_o == 2'b10) begin
                    chk("hsel_addr", bus.hsel_o, 1);
                    if (plan_q.size() == 0) begin
                        chk("nonseq_without_request", plan_q.size(), 1);
                    end else begin
                        cur = plan_q.pop_front();
                        chk("addr_phase_cycle", cyc, cur.hs_cyc + 1);
                        chk("haddr", bus.haddr_o, (cur.addr / SW) * SW);
                        chk("hwrite", bus.hwrite_o, cur.write);
                        chk("hsize", bus.hsize_o, $clog2(SW));
                        chk("hburst", bus.hburst_o, 0);
                        chk("hprot", bus.hprot_o, 3);
                        sub_busy = 1'b1;
                        k = 0;
                    end
                end
            end else begin
                chk("htrans_data", bus.htrans_o, 0);
                chk("hsel_data", bus.hsel_o, 0);
                chk("hready_o", bus.hready_o, bus.hreadyout_i);
                chk("hwdata", bus.hwdata_o, cur.write ? cur.wdata : '0);
                chk("hwstrb", bus.hwstrb_o, cur.write ? cur.wstrb : '0);
                bus.hreadyout_i = (k >= cur.waits);
                bus.hresp_i     = cur.err && (k >= cur.waits - 1);
                bus.hrdata_i    = (k >= cur.waits) ? cur.rdata : DW'($urandom);
                if (k >= cur.waits) sub_busy = 1'b0;
                k++;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response appears
    initial begin : rsp_monitor
        txn_t cur;
        int   hold = 0;
        bus.rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i === 1'b1) begin
                mon_active = 1'b0;
                bus.rsp_ready_i = 1'b0;
            end else if (bus.rsp_valid_o === 1'b1) begin
                if (!mon_active) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp_valid", bus.rsp_valid_o, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        mon_active = 1'b1;
                        hold = cur.hold;
                        chk("rsp_latency", cyc, cur.rsp_cyc);
                    end
                end
                if (mon_active) begin
                    chk("rsp_rdata", bus.rsp_rdata_o, (cur.write || cur.timeout) ? '0 : cur.rdata);
                    chk("rsp_err", bus.rsp_err_o, cur.err || cur.timeout);
                    chk("req_ready_in_resp", bus.req_ready_o, 0);
                    chk("timeout_o", bus.timeout_o, to_expected);
                    if (hold == 0) begin
                        bus.rsp_ready_i = 1'b1;
                    end else begin
                        hold--;
                        bus.rsp_ready_i = 1'b0;
                    end
                end
            end else begin
                if (mon_active) begin
                    if (!cur.timeout) chk("req_ready_after_resp", bus.req_ready_o, 1);
                    mon_active = 1'b0;
                end
                bus.rsp_ready_i = ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        txn_t t;
        int   hs;
        rst_i = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_wstrb_i = '0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_i = 1'b0;

        // zero-wait read, 3-wait write, two-cycle error, held response, empty strobes
        issue(mk(1'b0, 32'h100, '0, '0, 32'hDEADBEEF, 1'b0, 0, 0), hs);
        issue(mk(1'b1, 32'h104, 32'h12345678, 4'hF, DW'($urandom), 1'b0, 3, 0), hs);
        issue(mk(1'b0, 32'h200, '0, '0, 32'hA5A55A5A, 1'b1, 1, 1), hs);
        issue(mk(1'b0, 32'h10F, '0, '0, 32'h0BADF00D, 1'b0, 2, 5), hs);
        issue(mk(1'b1, 32'h2A6, 32'hFEEDC0DE, 4'h0, DW'($urandom), 1'b0, 0, 2), hs);

        for (int n = 0; n < 60; n++) begin
            t = mk($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), SW'($urandom),
                   DW'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 4),
                   $urandom_range(0, 3));
            if (t.err && t.waits == 0) t.waits = 1;
            issue(t, hs);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

`ifdef I3C_AHB_MGR_TIMEOUT_EN
        // subordinate stalls 20 cycles: aborted after TO_CYC waits, then drained
        t = mk(1'b0, 32'h300, '0, '0, 32'h13572468, 1'b0, 20, 0);
        t.timeout = 1'b1;
        to_expected = 1'b1;
        issue(t, hs);
        while (cyc < hs + 23) begin
            @(negedge clk);
            if (cyc < hs + 23) chk("req_ready_drain", bus.req_ready_o, 0);
        end
        chk("req_ready_after_drain", bus.req_ready_o, 1);
        chk("timeout_sticky", bus.timeout_o, 1);
        wait_idle();
`endif

        // reset in the middle of a long data phase drops the transfer silently
        issue(mk(1'b1, 32'h400, 32'hCAFEF00D, 4'hA, '0, 1'b0, 10, 0), hs);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        exp_q.delete();
        plan_q.delete();
        check_reset_values("mid_rst");
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", bus.rsp_valid_o, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
